// File: rtl/rd_burst_ctrl.sv
// Read-burst sequencer for the conv read mux: one command at a time, strided
// address stream with first/last markers, then a wait for the mux last data beat.
module rd_burst_ctrl #(
  parameter int AW  = 13,
  parameter int IFW = 5,
  parameter int LW  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [AW-1:0]  cmd_addr,
  input  logic [AW-1:0]  cmd_stride,
  input  logic [LW-1:0]  cmd_len,
  input  logic [IFW-1:0] cmd_info,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  output logic [IFW-1:0] info,
  output logic [AW-1:0]  m_addr,
  output logic           m_addr_first,
  output logic           m_addr_last,
  output logic           m_addr_valid,
  input  logic           m_addr_ready,
  input  logic           mon_valid,
  input  logic           mon_ready,
  input  logic           mon_last,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, ADDR, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AW-1:0]  stride_q, stride_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  beat_q, beat_d;
  logic [LW:0]    dcnt_q, dcnt_d;
  logic [IFW-1:0] info_q, info_d;
  logic           valid_q, valid_d;
  logic           first_q, first_d;
  logic           last_q, last_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           early_q, early_d;

  logic           addr_hs;
  logic           mon_hs;
  logic           mon_last_hs;
  logic [LW:0]    dcnt_inc;
  logic [LW:0]    beats_exp;
  logic           cnt_bad;

  // cmd_ready is the only combinational output; gating with rst_n keeps it low in reset.
  assign cmd_ready    = rst_n & (state_q == IDLE);
  assign info         = info_q;
  assign m_addr       = addr_q;
  assign m_addr_first = first_q;
  assign m_addr_last  = last_q;
  assign m_addr_valid = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

  assign addr_hs     = valid_q & m_addr_ready;
  assign mon_hs      = mon_valid & mon_ready;
  assign mon_last_hs = mon_hs & mon_last;
  assign dcnt_inc    = dcnt_q + (LW+1)'(1);
  assign beats_exp   = {1'b0, len_q} + (LW+1)'(1);
  assign cnt_bad     = (dcnt_inc != beats_exp);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // statement can leave a variable unassigned and infer a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    beat_d   = beat_q;
    dcnt_d   = dcnt_q;
    info_d   = info_q;
    valid_d  = valid_q;
    first_d  = first_q;
    last_d   = last_q;
    err_d    = err_q;
    early_d  = early_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = ADDR;
          addr_d   = cmd_addr;
          stride_d = cmd_stride;
          len_d    = cmd_len;
          info_d   = cmd_info;
          beat_d   = '0;
          dcnt_d   = '0;
          err_d    = 1'b0;
          early_d  = 1'b0;
          valid_d  = 1'b1;
          first_d  = 1'b1;
          last_d   = (cmd_len == '0);
        end
      end

      ADDR: begin
        if (mon_hs) dcnt_d = dcnt_inc;
        // Data can finish before the address stream does; remember it for DRAIN.
        if (mon_last_hs) begin
          early_d = 1'b1;
          if (cnt_bad) err_d = 1'b1;
        end
        if (addr_hs) begin
          if (beat_q == len_q) begin
            state_d = DRAIN;
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            beat_d  = beat_q + LW'(1);
            addr_d  = addr_q + stride_q;
            first_d = 1'b0;
            last_d  = ((beat_q + LW'(1)) == len_q);
          end
        end
      end

      DRAIN: begin
        if (mon_hs) dcnt_d = dcnt_inc;
        if (mon_last_hs && cnt_bad) err_d = 1'b1;
        if (early_q || mon_last_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      dcnt_q   <= '0;
      info_q   <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      early_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      dcnt_q   <= dcnt_d;
      info_q   <= info_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      early_q  <= early_d;
    end
  end

endmodule

// File: tb/tb_rd_burst_ctrl.sv
// Self-checking bench for rd_burst_ctrl: table-driven bursts plus hand-written
// early-last, back-to-back and mid-burst reset sequences.
module tb_rd_burst_ctrl;

  localparam int AW  = 13;
  localparam int IFW = 5;
  localparam int LW  = 8;

  logic           clk;
  logic           rst_n;
  logic [AW-1:0]  cmd_addr;
  logic [AW-1:0]  cmd_stride;
  logic [LW-1:0]  cmd_len;
  logic [IFW-1:0] cmd_info;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [IFW-1:0] info;
  logic [AW-1:0]  m_addr;
  logic           m_addr_first;
  logic           m_addr_last;
  logic           m_addr_valid;
  logic           m_addr_ready;
  logic           mon_valid;
  logic           mon_ready;
  logic           mon_last;
  logic           busy;
  logic           done;
  logic           err;

  rd_burst_ctrl #(.AW(AW), .IFW(IFW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
    .cmd_info(cmd_info), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .info(info), .m_addr(m_addr), .m_addr_first(m_addr_first),
    .m_addr_last(m_addr_last), .m_addr_valid(m_addr_valid),
    .m_addr_ready(m_addr_ready), .mon_valid(mon_valid), .mon_ready(mon_ready),
    .mon_last(mon_last), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [AW-1:0]  stride;
    logic [LW-1:0]  len;
    logic [IFW-1:0] info;
    logic [3:0]     rdy;    // m_addr_ready pattern, bit (cycle % 4)
    int             beats;  // monitor beats in DRAIN, last on the final one
    logic           xerr;   // expected err after completion
  } vec_t;

  vec_t vecs [5];
  vec_t v;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input vec_t vv, input int k);
    logic [AW-1:0] kk;
    kk = k[AW-1:0];
    return vv.addr + kk * vv.stride;
  endfunction

  // Drives a command at a negedge; returns at the negedge after acceptance.
  task automatic accept(input vec_t vv);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", cmd_ready, 1'b1);
    cmd_addr   = vv.addr;
    cmd_stride = vv.stride;
    cmd_len    = vv.len;
    cmd_info   = vv.info;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("accept_state", {busy, done, err, info}, {1'b1, 1'b0, 1'b0, vv.info});
  endtask

  // Starts at the negedge where beat 0 is visible; ends in DRAIN.
  task automatic addr_phase(input vec_t vv);
    int k = 0;
    int c = 0;
    while (k <= int'(vv.len) && c < 200) begin
      check("addr_beat", {m_addr_valid, m_addr_first, m_addr_last, m_addr, info},
            {1'b1, k == 0, k == int'(vv.len), exp_addr(vv, k), vv.info});
      m_addr_ready = vv.rdy[c % 4];
      @(negedge clk);
      if (m_addr_ready) k++;
      c++;
    end
    m_addr_ready = 1'b0;
    check("addr_budget", c < 200, 1'b1);
    check("drain_entry", {m_addr_valid, busy, done}, {1'b0, 1'b1, 1'b0});
  endtask

  task automatic drain_phase(input vec_t vv);
    for (int j = 1; j <= vv.beats; j++) begin
      check("drain_wait", {busy, done}, {1'b1, 1'b0});
      mon_valid = 1'b1;
      mon_ready = 1'b1;
      mon_last  = (j == vv.beats);
      @(negedge clk);
    end
    mon_valid = 1'b0;
    mon_ready = 1'b0;
    mon_last  = 1'b0;
    check("done_pulse", {done, busy, cmd_ready, err}, {1'b1, 1'b0, 1'b1, vv.xerr});
    @(negedge clk);
    check("idle_hold", {done, busy, err, info}, {1'b0, 1'b0, vv.xerr, vv.info});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{13'h0010, 13'h0001, 8'd3, 5'h13, 4'hF, 4, 1'b0};  // basic
    vecs[1] = '{13'h1FFE, 13'h0003, 8'd2, 5'h05, 4'hF, 3, 1'b0};  // stride + wrap
    vecs[2] = '{13'h0100, 13'h0002, 8'd4, 5'h1A, 4'b1001, 5, 1'b0};  // backpressure
    vecs[3] = '{13'h0ABC, 13'h0007, 8'd0, 5'h08, 4'hF, 1, 1'b0};  // single beat
    vecs[4] = '{13'h0200, 13'h0010, 8'd2, 5'h12, 4'hF, 2, 1'b1};  // short count

    rst_n = 1'b1;
    cmd_addr = '0; cmd_stride = '0; cmd_len = '0; cmd_info = '0; cmd_valid = 1'b0;
    m_addr_ready = 1'b0; mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    check("reset_outputs",
          {cmd_ready, info, m_addr, m_addr_first, m_addr_last, m_addr_valid, busy, done, err}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", {cmd_ready, busy, done, err, m_addr_valid}, {1'b1, 4'b0000});

    for (int i = 0; i < 5; i++) begin
      accept(vecs[i]);
      addr_phase(vecs[i]);
      drain_phase(vecs[i]);
    end

    // Monitor traffic in IDLE must not complete anything or touch err.
    mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
    @(negedge clk);
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    check("idle_mon_ignored", {done, busy, err, cmd_ready}, {1'b0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    check("idle_mon_no_done", done, 1'b0);

    // Early last: monitor last during ADDR, done two cycles after the last address handshake.
    v = '{13'h0040, 13'h0004, 8'd2, 5'h07, 4'hF, 0, 1'b1};
    accept(v);
    m_addr_ready = 1'b1;
    @(negedge clk);
    mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
    @(negedge clk);
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    check("early_err", {err, m_addr, m_addr_last, m_addr_valid}, {1'b1, 13'h0048, 1'b1, 1'b1});
    @(negedge clk);
    m_addr_ready = 1'b0;
    check("early_drain", {m_addr_valid, busy, done}, {1'b0, 1'b1, 1'b0});
    @(negedge clk);
    check("early_done", {done, busy, err, cmd_ready}, {1'b1, 1'b0, 1'b1, 1'b1});

    // Back-to-back: second command held while busy is accepted on the done cycle.
    @(negedge clk);
    cmd_addr = 13'h0100; cmd_stride = 13'h0001; cmd_len = 8'd0; cmd_info = 5'h11;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_addr = 13'h0200; cmd_stride = 13'h0010; cmd_len = 8'd1; cmd_info = 5'h0A;
    check("b2b_a_beat", {cmd_ready, m_addr, m_addr_first, m_addr_last, info, err},
          {1'b0, 13'h0100, 1'b1, 1'b1, 5'h11, 1'b0});
    m_addr_ready = 1'b1;
    @(negedge clk);
    m_addr_ready = 1'b0;
    check("b2b_a_drain", {cmd_ready, m_addr_valid, busy}, {1'b0, 1'b0, 1'b1});
    mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
    @(negedge clk);
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    check("b2b_a_done", {done, cmd_ready, busy, info}, {1'b1, 1'b1, 1'b0, 5'h11});
    @(negedge clk);
    cmd_valid = 1'b0;
    v = '{13'h0200, 13'h0010, 8'd1, 5'h0A, 4'hF, 2, 1'b0};
    check("b2b_b_accept", {busy, done, info, cmd_ready}, {1'b1, 1'b0, 5'h0A, 1'b0});
    addr_phase(v);
    drain_phase(v);

    // Reset in the middle of the address stream.
    v = '{13'h0300, 13'h0001, 8'd5, 5'h1F, 4'hF, 0, 1'b0};
    accept(v);
    m_addr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_mid", {m_addr, m_addr_valid}, {13'h0302, 1'b1});
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs",
          {cmd_ready, info, m_addr, m_addr_first, m_addr_last, m_addr_valid, busy, done, err}, '0);
    m_addr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_mid", {cmd_ready, busy, done, m_addr_valid, info}, {1'b1, 8'h00});
    @(negedge clk);
    check("after_reset_no_done", {done, busy}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rd_burst_ctrl.md
# rd_burst_ctrl

Read-burst sequencer for the conv read mux. It accepts one command at a time, holds the mux `info` field stable, issues a strided address stream with first/last markers on the mux address channel, and waits for the matching last data beat to leave the mux before accepting the next command. This prevents channel-mask or memory-select changes while data is still in flight.

## Interface
Parameters:
- `AW`, 13, address width.
- `IFW`, 5, info width: bit 4 is ram_sel, bit 3 is mem_sel, bits 2:0 are channel.
- `LW`, 8, burst-length field width.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_addr`  in  AW  start address.
- `cmd_stride`  in  AW  address increment per beat.
- `cmd_len`  in  LW  beats minus one.
- `cmd_info`  in  IFW  info for this burst.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `info`  out  IFW  info driven to the mux.
- `m_addr`  out  AW  address beat.
- `m_addr_first`  out  1  first address beat marker.
- `m_addr_last`  out  1  last address beat marker.
- `m_addr_valid`  out  1  address valid.
- `m_addr_ready`  in  1  address ready.
- `mon_valid`  in  1  tap of the mux output data valid.
- `mon_ready`  in  1  tap of the mux output data ready.
- `mon_last`  in  1  tap of the mux output data last.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse at burst completion.
- `err`  out  1  sticky beat-count mismatch flag.

## Operation
- FSM states: IDLE, ADDR, DRAIN. Reset state is IDLE.
- IDLE:
  - `cmd_ready=1`.
  - On accept, latch addr/stride/len/info, clear the address counter, data counter, `err` and the early-last flag, then go to ADDR.
- ADDR:
  - `m_addr_valid=1`.
  - Beat k (0..len) presents `m_addr = cmd_addr + k*cmd_stride` mod 2^AW (wrap-around, no carry out).
  - `m_addr_first=1` when k==0; `m_addr_last=1` when k==len. With len=0 both are set on the single beat.
  - Beat advances only on `m_addr_valid & m_addr_ready`; fields hold while stalled.
  - On handshake of beat len go to DRAIN.
- DRAIN:
  - `m_addr_valid=0`.
  - On a monitor handshake (`mon_valid & mon_ready & mon_last`), go to IDLE and pulse `done`.
  - If the early-last flag is set, go to IDLE with `done` on the first DRAIN cycle.
- Data counter: counts monitor handshakes (`mon_valid & mon_ready`) in ADDR and DRAIN, width LW+1.
- `err`: at the monitor last handshake, if count including that beat != len+1, set `err` (sticky until next command accept).
- Early last: a monitor last handshake during ADDR sets the early-last flag. The same count check applies.
- `info` changes only on command accept and otherwise holds, including in IDLE after a burst.
- Monitor handshakes in IDLE are ignored.

## Timing
- Reset values: `cmd_ready=0` during reset and 1 from the first cycle after release. `info=0`, `m_addr=0`, first/last/valid=0, `busy=0`, `done=0`, `err=0`.
- All outputs except `cmd_ready` are registered.
- Command accepted at cycle T: `info`, `m_addr` (beat 0) and `m_addr_valid` are valid at T+1; `busy=1` from T+1.
- With `m_addr_ready` held high, one beat issues per cycle; beat len handshakes at T+1+len.
- Monitor last handshake at cycle D (in DRAIN): `done=1`, `busy=0` and `cmd_ready=1` at D+1. A new command may be accepted at D+1.
- Early-last case: last address handshake at cycle A, so DRAIN starts at A+1; `done` at A+2.
- Reset asserted mid-burst: immediately return to IDLE with all outputs at reset values; the in-flight burst is abandoned with no `done`.

## Test plan
- **Basic burst.** Reset, then cmd addr=0x010, stride=1, len=3, info=0x13, `m_addr_ready=1`.
  - Addresses 0x010..0x013 on consecutive cycles; first on 0x010, last on 0x013; `info=0x13` throughout.
  - After 4 monitor beats with last on beat 4: `done` pulses once, `err=0`.
- **Stride and wrap.** addr=0x1FFE, stride=3, len=2, AW=13.
  - Addresses 0x1FFE, 0x0001, 0x0004.
- **Backpressure.** Toggle `m_addr_ready` 1,0,0,1,… with len=4.
  - Address/first/last hold while stalled; exactly 5 handshakes, no beat skipped or duplicated.
- **Single beat and short count.** len=0.
  - One beat with first=last=1.
  - Monitor last on the 1st beat: `done`, `err=0`.
  - Repeat with len=2 and monitor last on the 2nd beat: `done`, `err=1`; the next accept clears `err`.
- **Back-to-back and reset.**
  - Second command asserted while busy: stalls (`cmd_ready=0`) until the cycle `done` is high, then is accepted that cycle.
  - Reset asserted mid-ADDR: all outputs return to reset values, no `done`.
